// File: rtl/vip_conv2d_pkg.sv
// Shared definitions for the conv2d feature-map input packer: default sizes,
// FSM state encoding and channel lane indices.
package vip_conv2d_pkg;

   localparam int DWIDTH_DEF = 32;
   localparam int PIXELS_DEF = 12544;
   localparam int CNT_W_DEF  = 14;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GATHER = 2'd1,
      ST_PUSH   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [1:0] LANE0 = 2'd0;
   localparam logic [1:0] LANE1 = 2'd1;
   localparam logic [1:0] LANE2 = 2'd2;

endpackage

// File: rtl/vip_featuremap_conv2d_in_packer.sv
// Packs three consecutive channel words from a show-ahead source FIFO into one
// {ch2,ch1,ch0} pixel word and writes it to the conv input FIFO, one frame per start.
module vip_featuremap_conv2d_in_packer
   import vip_conv2d_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int PIXELS = PIXELS_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic [DWIDTH-1:0]     src_rdata,
   output logic                  src_rdreq,
   input  logic                  src_empty,
   output logic [3*DWIDTH-1:0]   fifo_in_data,
   output logic                  fifo_in_wrreq,
   input  logic                  fifo_in_full,
   output logic [CNT_W-1:0]      pix_count
);

   if ((64'd1 << CNT_W) <= 64'(PIXELS)) begin : g_cnt_w_check
      $error("CNT_W too narrow to hold PIXELS");
   end

   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS - 1);

   state_t                state;
   logic [1:0]            ch_idx;
   logic [CNT_W-1:0]      pix_cnt;
   logic [3*DWIDTH-1:0]   pack;
   logic                  pop;
   logic                  push;

   // Pop and write are mutually exclusive because they live in different states.
   assign pop  = (state == ST_GATHER) && !src_empty;
   assign push = (state == ST_PUSH) && !fifo_in_full;

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_IDLE;
         ch_idx  <= LANE0;
         pix_cnt <= '0;
         pack    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_GATHER;
                  pix_cnt <= '0;
                  ch_idx  <= LANE0;
               end
            end
            ST_GATHER: begin
               if (pop) begin
                  case (ch_idx)
                     LANE0:   pack[DWIDTH-1:0]          <= src_rdata;
                     LANE1:   pack[2*DWIDTH-1:DWIDTH]   <= src_rdata;
                     default: pack[3*DWIDTH-1:2*DWIDTH] <= src_rdata;
                  endcase
                  if (ch_idx == LANE2) begin
                     ch_idx <= LANE0;
                     state  <= ST_PUSH;
                  end else begin
                     ch_idx <= ch_idx + 2'd1;
                  end
               end
            end
            ST_PUSH: begin
               if (push) begin
                  pix_cnt <= pix_cnt + 1'b1;
                  state   <= (pix_cnt == LAST_PIX) ? ST_DONE : ST_GATHER;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy          = (state != ST_IDLE);
   assign done          = (state == ST_DONE);
   assign src_rdreq     = pop;
   assign fifo_in_wrreq = push;
   assign fifo_in_data  = pack;
   assign pix_count     = pix_cnt;

endmodule

// File: doc/vip_featuremap_conv2d_in_packer.md
Name: vip_featuremap_conv2d_in_packer

Overview:
- Producer-side feeder for the conv2d feature-map stage.
- Drains 32-bit single-channel words from a show-ahead source FIFO and packs each group of three consecutive words (ch0, ch1, ch2) into one 3*DWIDTH pixel word.
- Writes each pixel word into the conv stage's input FIFO (fifo_in_data / fifo_in_wrreq / fifo_in_full), honouring backpressure.
- Frames are bounded by a pixel counter; start/busy/done give a per-frame handshake to the controller.

Parameters:
- DWIDTH, 32, width of one channel word.
- PIXELS, 12544, pixels per frame (112x112).
- CNT_W, 14, width of pixel counter; must satisfy 2^CNT_W > PIXELS.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begins a frame; honoured only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after last pixel written
- src_rdata  in  DWIDTH  source FIFO head word, valid whenever src_empty=0 (show-ahead)
- src_rdreq  out  1  pops source FIFO head
- src_empty  in  1  source FIFO empty
- fifo_in_data  out  3*DWIDTH  packed pixel {ch2,ch1,ch0}
- fifo_in_wrreq  out  1  write strobe to conv input FIFO
- fifo_in_full  in  1  conv input FIFO full
- pix_count  out  CNT_W  pixels written in the current/last frame

Behaviour:
- Reset (synchronous, active-high, clock only): state=IDLE, ch_idx=0, pix_cnt=0, pack register=0. Outputs: busy=0, done=0, src_rdreq=0, fifo_in_wrreq=0, fifo_in_data=0, pix_count=0.
- States: IDLE, GATHER, PUSH, DONE.
- IDLE: start=1 -> GATHER; pix_cnt<=0, ch_idx<=0.
- GATHER:
  - src_rdreq = !src_empty (combinational).
  - On a pop, src_rdata is latched into lane ch_idx: lane0=[DWIDTH-1:0], lane1=[2*DWIDTH-1:DWIDTH], lane2=[3*DWIDTH-1:2*DWIDTH].
  - ch_idx increments; when the pop fills lane2, ch_idx<=0 and next state is PUSH.
  - src_empty=1: stall in GATHER, no pop, lanes hold.
- PUSH:
  - fifo_in_wrreq = !fifo_in_full (combinational); fifo_in_data = pack register (stable throughout PUSH).
  - Write accepted (wrreq=1): pix_cnt<=pix_cnt+1. If pix_cnt==PIXELS-1 -> DONE, else -> GATHER.
  - fifo_in_full=1: hold in PUSH, no write, no pop.
- DONE: done=1 for exactly one cycle -> IDLE. pix_count holds PIXELS until the next start.
- src_rdreq is never asserted outside GATHER; fifo_in_wrreq is never asserted outside PUSH. No simultaneous pop and write.
- Latency and throughput:
  - Minimum 4 cycles per pixel (3 pops + 1 push).
  - First wrreq occurs no earlier than 4 cycles after start.
  - done is asserted the cycle after the last write.
- start while busy: ignored, no effect on the counter.
- Reset mid-frame: partial pixel and count discarded; already-written pixels are not recalled. The downstream FIFO is reset by the same reset.
- pix_cnt never wraps, since PIXELS < 2^CNT_W; the frame ends exactly at PIXELS.

Decomposition:
- Shared package vip_conv2d_pkg: DWIDTH, PIXELS, state encoding (IDLE=2'd0, GATHER=2'd1, PUSH=2'd2, DONE=2'd3), lane-index constants.
- No sub-module needed. FSM, lane register and counter fit in one module; instantiated alongside vip_top_featuremap_conv2d_0_filter4 in the system top.

Test Plan:
1. Reset, then start with PIXELS=4; source preloaded with words 0x01..0x0C, fifo_in_full=0.
   - Expected: 4 writes of 0x00000003_00000002_00000001, 0x..06_..05_..04, 0x..09_..08_..07, 0x..0C_..0B_..0A.
   - Writes are 4 cycles apart; done pulses once; pix_count=4.
2. Source starved: src_empty=1 after the 2nd word for 10 cycles.
   - Expected: stays in GATHER, no rdreq, no wrreq; resumes on refill; pixel contents correct.
3. Backpressure: fifo_in_full=1 for 5 cycles during PUSH.
   - Expected: wrreq=0 and fifo_in_data stable for those 5 cycles, no src pops; exactly one write after full drops.
4. start pulsed mid-frame (busy=1).
   - Expected: ignored; frame completes with pix_count=PIXELS and a single done.
5. reset asserted after 2 pixels and 1 word of pixel 3.
   - Expected: next cycle all outputs 0, state IDLE; a new start packs the next 3 source words as a fresh pixel.
6. Back-to-back frames: start pulsed on the cycle after done.
   - Expected: second frame starts, pix_count restarts from 0, total writes = 2*PIXELS.
